// File: rtl/oh_clkgate_ctrl.sv
// oh_clkgate_ctrl: idle-detect and wake sequencer driving an ICG enable.
// Watches per-channel busy/req levels on the free-running clock, gates the
// downstream clock after a programmable idle window, re-enables it on demand
// and acks requesters once the gated domain has settled.
// Optional gated-cycle statistic counter: define OH_CLKGATE_STATS_EN.
module oh_clkgate_ctrl #(
  parameter int unsigned N  = 4,
  parameter int unsigned CW = 8,
  parameter int unsigned WW = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cfg_enable,
  input  logic [CW-1:0] cfg_idle,
  input  logic [WW-1:0] cfg_wake,
  input  logic          te,
  input  logic [N-1:0]  busy,
  input  logic [N-1:0]  req,
  output logic [N-1:0]  ack,
  output logic          icg_en,
  output logic          gated,
  output logic [31:0]   gated_cnt,
  input  logic          stat_clr
);

  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_COUNT = 2'd1;
  localparam logic [1:0] ST_GATED = 2'd2;
  localparam logic [1:0] ST_WAKE  = 2'd3;

  logic [1:0]    state_q,    state_d;
  logic [CW-1:0] idle_cnt_q, idle_cnt_d;
  logic [WW-1:0] wake_cnt_q, wake_cnt_d;
  logic          icg_en_q,   icg_en_d;
  logic          gated_q,    gated_d;
  logic [N-1:0]  ack_q,      ack_d;
  logic          idle_c;

  // Domain is idle only when gating is allowed and nobody wants the clock
  always_comb begin
    idle_c = cfg_enable & ~te & ~(|busy) & ~(|req);
  end

  // Next-state and counter logic; counts compare with >= so that a lowered
  // threshold ends the count at the next compare instead of wrapping
  always_comb begin
    state_d    = state_q;
    idle_cnt_d = idle_cnt_q;
    wake_cnt_d = wake_cnt_q;
    case (state_q)
      ST_RUN: begin
        if (idle_c) begin
          if (cfg_idle == '0) begin
            state_d    = ST_GATED;
            idle_cnt_d = '0;
          end else begin
            state_d    = ST_COUNT;
            idle_cnt_d = CW'(1);
          end
        end else begin
          idle_cnt_d = '0;
        end
      end
      ST_COUNT: begin
        if (!idle_c) begin
          state_d    = ST_RUN;
          idle_cnt_d = '0;
        end else if (idle_cnt_q >= cfg_idle) begin
          state_d    = ST_GATED;
          idle_cnt_d = '0;
        end else begin
          idle_cnt_d = idle_cnt_q + CW'(1);
        end
      end
      ST_GATED: begin
        if (!idle_c) begin
          state_d    = ST_WAKE;
          wake_cnt_d = '0;
        end
      end
      ST_WAKE: begin
        // Settle window runs to completion even if the activity goes away
        if (wake_cnt_q >= cfg_wake) begin
          state_d    = ST_RUN;
          wake_cnt_d = '0;
        end else begin
          wake_cnt_d = wake_cnt_q + WW'(1);
        end
      end
      default: begin
        state_d    = ST_RUN;
        idle_cnt_d = '0;
        wake_cnt_d = '0;
      end
    endcase
  end

  // Registered outputs derived from the next state; ack is granted only
  // once the domain has spent a full cycle back in RUN after any wake-up
  always_comb begin
    icg_en_d = (state_d != ST_GATED);
    gated_d  = (state_d == ST_GATED);
    ack_d    = req & {N{(state_q == ST_RUN) && (state_d == ST_RUN)}};
  end

  // State and output registers with synchronous reset to a running clock
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_RUN;
      idle_cnt_q <= '0;
      wake_cnt_q <= '0;
      icg_en_q   <= 1'b1;
      gated_q    <= 1'b0;
      ack_q      <= '0;
    end else begin
      state_q    <= state_d;
      idle_cnt_q <= idle_cnt_d;
      wake_cnt_q <= wake_cnt_d;
      icg_en_q   <= icg_en_d;
      gated_q    <= gated_d;
      ack_q      <= ack_d;
    end
  end

  assign icg_en = icg_en_q;
  assign gated  = gated_q;
  assign ack    = ack_q;

`ifdef OH_CLKGATE_STATS_EN
  logic [31:0] gated_cnt_q, gated_cnt_d;

  // Saturating count of cycles spent gated; clear beats increment
  always_comb begin
    gated_cnt_d = gated_cnt_q;
    if (stat_clr) begin
      gated_cnt_d = '0;
    end else if (gated_q && (gated_cnt_q != 32'hFFFF_FFFF)) begin
      gated_cnt_d = gated_cnt_q + 32'd1;
    end
  end

  // Statistic register
  always_ff @(posedge clk) begin
    if (reset) begin
      gated_cnt_q <= '0;
    end else begin
      gated_cnt_q <= gated_cnt_d;
    end
  end

  assign gated_cnt = gated_cnt_q;
`else
  logic unused_stat_clr;

  assign unused_stat_clr = stat_clr;
  assign gated_cnt       = 32'd0;
`endif

endmodule
